// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: hard-wired fetch/execute control sequencer that drives the cpu datapath strobes.
// Revision 1.0 - initial release
`default_nettype none

module alu_instr_sequencer #(
  parameter int               NUM_REGS = 16,
  parameter int               RA_W     = 4,
  parameter int               OP_W     = 5,
  parameter logic [OP_W-1:0]  OPC_ADDI = 5'b01100,
  parameter logic [OP_W-1:0]  OPC_ANDI = 5'b01101,
  parameter logic [OP_W-1:0]  OPC_ORI  = 5'b01110,
  parameter logic [OP_W-1:0]  OPC_MUL  = 5'b01111,
  parameter logic [OP_W-1:0]  OPC_DIV  = 5'b10000,
  parameter logic [OP_W-1:0]  ALU_ADD  = 5'b00011,
  parameter logic [OP_W-1:0]  ALU_AND  = 5'b00101,
  parameter logic [OP_W-1:0]  ALU_OR   = 5'b00110,
  parameter logic [OP_W-1:0]  OPC_MAX  = 5'b10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRread,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Cout,
  output logic                Zhigh_enable,
  output logic                Zlow_enable,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HI_enable,
  output logic                LO_enable,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal_op
);

  localparam int RA_LSB = 32 - OP_W - RA_W;
  localparam int RB_LSB = RA_LSB - RA_W;
  localparam int RC_LSB = RB_LSB - RA_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0] op;
  logic [RA_W-1:0] ra, rb, rc;
  logic            is_imm, is_muldiv, is_illegal;
  logic [OP_W-1:0] imm_alu_op;
  logic            unused_ir_bits;

  assign op             = ir[31 -: OP_W];
  assign ra             = ir[RA_LSB +: RA_W];
  assign rb             = ir[RB_LSB +: RA_W];
  assign rc             = ir[RC_LSB +: RA_W];
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  assign is_imm     = (op == OPC_ADDI) || (op == OPC_ANDI) || (op == OPC_ORI);
  assign is_muldiv  = (op == OPC_MUL) || (op == OPC_DIV);
  assign is_illegal = (op > OPC_MAX);

  always_comb begin
    imm_alu_op = ALU_OR;
    if (op == OPC_ADDI)      imm_alu_op = ALU_ADD;
    else if (op == OPC_ANDI) imm_alu_op = ALU_AND;
  end

  // Register indices at or above NUM_REGS decode to no select line at all.
  function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [RA_W-1:0] idx);
    sel_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == RA_W'(i)) sel_onehot[i] = 1'b1;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   begin
        if (is_illegal) state_d = run ? S_T0 : S_IDLE;
        else            state_d = S_T4;
      end
      S_T4:   state_d = S_T5;
      S_T5:   begin
        if (is_muldiv) state_d = S_T6;
        else           state_d = run ? S_T0 : S_IDLE;
      end
      S_T6:   state_d = run ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCout        = 1'b0;
    PCin         = 1'b0;
    IncPC        = 1'b0;
    MARin        = 1'b0;
    MDRread      = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    Cout         = 1'b0;
    Zhigh_enable = 1'b0;
    Zlow_enable  = 1'b0;
    Zhighout     = 1'b0;
    Zlowout      = 1'b0;
    HI_enable    = 1'b0;
    LO_enable    = 1'b0;
    reg_in       = '0;
    reg_out      = '0;
    alu_op       = '0;
    done         = 1'b0;
    illegal_op   = 1'b0;
    busy         = (state_q != S_IDLE);
    case (state_q)
      S_T0: begin
        PCout       = 1'b1;
        MARin       = 1'b1;
        IncPC       = 1'b1;
        Zlow_enable = 1'b1;
      end
      S_T1: begin
        // While memory is not ready only the read request is held.
        MDRread = 1'b1;
        if (mem_ready) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
          MDRin   = 1'b1;
        end
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        // An illegal opcode drives nothing onto the bus.
        if (is_illegal) begin
          illegal_op = 1'b1;
        end else begin
          reg_out = sel_onehot(rb);
          Yin     = 1'b1;
        end
      end
      S_T4: begin
        Zlow_enable = 1'b1;
        if (is_imm) begin
          Cout   = 1'b1;
          alu_op = imm_alu_op;
        end else begin
          reg_out      = is_muldiv ? sel_onehot(ra) : sel_onehot(rc);
          alu_op       = op;
          Zhigh_enable = 1'b1;
        end
      end
      S_T5: begin
        if (is_muldiv) begin
          Zhighout  = 1'b1;
          HI_enable = 1'b1;
        end else begin
          Zlowout = 1'b1;
          reg_in  = sel_onehot(ra);
          done    = 1'b1;
        end
      end
      S_T6: begin
        Zlowout   = 1'b1;
        LO_enable = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: scoreboard bench; stimulus queues per-cycle expected strobes, monitor compares.
`default_nettype none

module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready;
  logic [31:0] ir;
  logic PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin, Yin, Cout;
  logic Zhigh_enable, Zlow_enable, Zhighout, Zlowout, HI_enable, LO_enable;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  alu_op;
  logic        busy, done, illegal_op;

  alu_instr_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRread(MDRread),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Cout(Cout),
    .Zhigh_enable(Zhigh_enable), .Zlow_enable(Zlow_enable), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] PCO = 16'h8000, PCI = 16'h4000, INC = 16'h2000, MAR = 16'h1000;
  localparam logic [15:0] MRD = 16'h0800, MDI = 16'h0400, MDO = 16'h0200, IRI = 16'h0100;
  localparam logic [15:0] YIN = 16'h0080, CO  = 16'h0040, ZHE = 16'h0020, ZLE = 16'h0010;
  localparam logic [15:0] ZHO = 16'h0008, ZLO = 16'h0004, HIE = 16'h0002, LOE = 16'h0001;

  typedef struct packed {
    logic [15:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        dn;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_busy   = 0;
  int   n_step   = 0;

  function automatic exp_t mk(logic [15:0] s, logic [15:0] ri, logic [15:0] ro,
                              logic [4:0] a, logic d, logic il);
    return {s, ri, ro, a, d, il};
  endfunction

  function automatic exp_t actual();
    return {{PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin, Yin, Cout,
             Zhigh_enable, Zlow_enable, Zhighout, Zlowout, HI_enable, LO_enable},
            reg_in, reg_out, alu_op, done, illegal_op};
  endfunction

  // Monitor: every busy cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      exp_t a, e;
      a = actual();
      n_busy++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL trace_unexpected step=%0d got=%h required=none", n_step, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL trace step=%0d got=%h required=%h", n_step, a, e);
        end
      end
      n_step++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input int waits);
    exp_q.push_back(mk(PCO | MAR | INC | ZLE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    for (int i = 0; i < waits; i++) exp_q.push_back(mk(MRD, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(ZLO | PCI | MRD | MDI, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(MDO | IRI, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
  endtask

  // SUB r0,r4,r5 : T3 drives r4, T4 drives r5, T5 loads r0.
  task automatic push_sub_exec(input bit full);
    exp_q.push_back(mk(YIN, 16'h0, 16'h0010, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(ZLE | ZHE, 16'h0, 16'h0020, 5'b00100, 1'b0, 1'b0));
    if (full) exp_q.push_back(mk(ZLO, 16'h0001, 16'h0, 5'd0, 1'b1, 1'b0));
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0 || actual() !== '0) begin
      failures++;
      $display("FAIL %s got busy=%b outs=%h required busy=0 outs=0", name, busy, actual());
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle_timeout got busy=%b required=0", busy);
    end
  endtask

  initial begin
    int start;
    reset = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'h0;
    repeat (2) step();
    check_idle("reset_state");
    reset = 1'b0;

    // Case 1: SUB, no memory wait
    push_fetch(0); push_sub_exec(1);
    start = n_busy;
    ir = 32'h2022_8000; run = 1'b1;
    step(); run = 1'b0;
    wait_idle(30);
    check_val("sub_latency", n_busy - start, 6);
    check_idle("sub_idle");

    // Case 2: same, three T1 wait cycles
    push_fetch(3); push_sub_exec(1);
    start = n_busy;
    run = 1'b1;
    step(); run = 1'b0; mem_ready = 1'b0;
    repeat (3) step();
    step(); mem_ready = 1'b1;
    wait_idle(30);
    check_val("wait_latency", n_busy - start, 9);

    // Case 3: ADDI r3,r4,7
    push_fetch(0);
    exp_q.push_back(mk(YIN, 16'h0, 16'h0010, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(CO | ZLE, 16'h0, 16'h0, 5'b00011, 1'b0, 1'b0));
    exp_q.push_back(mk(ZLO, 16'h0008, 16'h0, 5'd0, 1'b1, 1'b0));
    start = n_busy;
    ir = 32'h61A0_0007; run = 1'b1;
    step(); run = 1'b0;
    wait_idle(30);
    check_val("addi_latency", n_busy - start, 6);

    // Case 4: MUL r4,r8 (rb=8 first, ra=4 second operand)
    push_fetch(0);
    exp_q.push_back(mk(YIN, 16'h0, 16'h0100, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(ZLE | ZHE, 16'h0, 16'h0010, 5'b01111, 1'b0, 1'b0));
    exp_q.push_back(mk(ZHO | HIE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(ZLO | LOE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0));
    start = n_busy;
    ir = 32'h7A40_0000; run = 1'b1;
    step(); run = 1'b0;
    wait_idle(30);
    check_val("mul_latency", n_busy - start, 7);

    // Case 5: illegal opcode with run held, refetches straight into SUB
    push_fetch(0);
    exp_q.push_back(mk(16'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1));
    push_fetch(0); push_sub_exec(1);
    start = n_busy;
    ir = 32'hF800_0000; run = 1'b1;
    repeat (5) step();
    ir = 32'h2022_8000; run = 1'b0;
    wait_idle(30);
    check_val("illegal_latency", n_busy - start, 10);

    // Case 6: reset during T4 aborts before writeback
    push_fetch(0); push_sub_exec(0);
    start = n_busy;
    run = 1'b1;
    step(); run = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    check_idle("abort_idle");
    reset = 1'b0;
    step();
    check_idle("abort_stays_idle");
    check_val("abort_cycles", n_busy - start, 5);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
